// File: rtl/cpu_io_pkg.sv
// Shared defaults and helpers for the CPU I/O responder slice.
package cpu_io_pkg;

    localparam int unsigned DefWidth = 8;
    localparam int unsigned DefDepth = 16;
    localparam logic [DefWidth-1:0] DefEmptyValue = 8'd0;

    // Occupancy must represent 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/cpu_io_responder_if.sv
// CPU-side data port: the CPU (master) consumes I and emits O.
interface cpu_io_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] I;
    logic             IEnable;
    logic [WIDTH-1:0] O;
    logic             OEnable;

    modport master (input I, output IEnable, output O, output OEnable);
    modport slave  (output I, input IEnable, input O, input OEnable);

endinterface

// File: rtl/cpu_io_responder_sync_fifo.sv
// Synchronous FIFO with combinational head; a pop on a full FIFO frees room for a same-cycle push.
module sync_fifo
    import cpu_io_pkg::*;
#(
    parameter int unsigned Width = DefWidth,
    parameter int unsigned Depth = DefDepth
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic                        pop,
    input  logic [Width-1:0]            wdata,
    output logic [Width-1:0]            rdata,
    output logic                        full,
    output logic                        empty,
    output logic [cnt_width(Depth)-1:0] count
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = cnt_width(Depth);

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             push_ok, pop_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CntW'(Depth));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign rdata   = mem[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/cpu_io_responder.sv
// Deterministic data source/sink on the CPU I/O port, backed by two FIFOs.
// Optional CPU_IO_RESPONDER_STATS_EN adds saturating words_in/words_out counters.
module cpu_io_responder
    import cpu_io_pkg::*;
#(
    parameter int unsigned      WIDTH       = DefWidth,
    parameter int unsigned      DEPTH       = DefDepth,
    parameter logic [WIDTH-1:0] EMPTY_VALUE = WIDTH'(DefEmptyValue)
) (
    input  logic                        clk,
    input  logic                        rst,
    cpu_io_if.slave                     cpu,
    input  logic                        in_wr,
    input  logic [WIDTH-1:0]            in_data,
    output logic                        in_full,
    output logic [cnt_width(DEPTH)-1:0] in_count,
    input  logic                        out_rd,
    output logic [WIDTH-1:0]            out_data,
    output logic                        out_valid,
    output logic [cnt_width(DEPTH)-1:0] out_count,
    output logic                        in_underrun,
    output logic                        out_overflow
`ifdef CPU_IO_RESPONDER_STATS_EN
    ,
    output logic [15:0]                 words_in,
    output logic [15:0]                 words_out
`endif
);

    logic [WIDTH-1:0] in_head;
    logic             in_empty;
    logic             out_full;
    logic             out_empty;
    logic             in_underrun_q, out_overflow_q;
    logic             cpu_pop_ok, cpu_push_ok;

    sync_fifo #(
        .Width (WIDTH),
        .Depth (DEPTH)
    ) u_in_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_wr),
        .pop   (cpu.IEnable),
        .wdata (in_data),
        .rdata (in_head),
        .full  (in_full),
        .empty (in_empty),
        .count (in_count)
    );

    sync_fifo #(
        .Width (WIDTH),
        .Depth (DEPTH)
    ) u_out_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cpu.OEnable),
        .pop   (out_rd),
        .wdata (cpu.O),
        .rdata (out_data),
        .full  (out_full),
        .empty (out_empty),
        .count (out_count)
    );

    assign cpu.I     = in_empty ? EMPTY_VALUE : in_head;
    assign out_valid = !out_empty;

    // Mirrors the FIFOs' acceptance rules so flags and stats agree with them.
    assign cpu_pop_ok  = cpu.IEnable && !in_empty;
    assign cpu_push_ok = cpu.OEnable && (!out_full || (out_rd && !out_empty));

    always_ff @(posedge clk) begin
        if (rst) begin
            in_underrun_q  <= 1'b0;
            out_overflow_q <= 1'b0;
        end else begin
            if (cpu.IEnable && in_empty)   in_underrun_q  <= 1'b1;
            if (cpu.OEnable && !cpu_push_ok) out_overflow_q <= 1'b1;
        end
    end

    assign in_underrun  = in_underrun_q;
    assign out_overflow = out_overflow_q;

`ifdef CPU_IO_RESPONDER_STATS_EN
    logic [15:0] words_in_q, words_out_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            words_in_q  <= '0;
            words_out_q <= '0;
        end else begin
            if (cpu_pop_ok  && !(&words_in_q))  words_in_q  <= words_in_q + 16'd1;
            if (cpu_push_ok && !(&words_out_q)) words_out_q <= words_out_q + 16'd1;
        end
    end

    assign words_in  = words_in_q;
    assign words_out = words_out_q;
`else
    logic unused_stats;
    assign unused_stats = cpu_pop_ok ^ cpu_push_ok;
`endif

endmodule

// File: tb/tb_cpu_io_responder.sv
// Directed self-checking bench for cpu_io_responder (DEPTH 16, WIDTH 8, EMPTY_VALUE 0).
module tb_cpu_io_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_wr;
    logic [7:0] in_data;
    logic       in_full;
    logic [4:0] in_count;
    logic       out_rd;
    logic [7:0] out_data;
    logic       out_valid;
    logic [4:0] out_count;
    logic       in_underrun;
    logic       out_overflow;
`ifdef CPU_IO_RESPONDER_STATS_EN
    logic [15:0] words_in;
    logic [15:0] words_out;
`endif

    int checks = 0;
    int errors = 0;

    cpu_io_if #(.WIDTH(8)) cpu ();

    cpu_io_responder #(
        .WIDTH       (8),
        .DEPTH       (16),
        .EMPTY_VALUE (8'd0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cpu          (cpu),
        .in_wr        (in_wr),
        .in_data      (in_data),
        .in_full      (in_full),
        .in_count     (in_count),
        .out_rd       (out_rd),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_count    (out_count),
        .in_underrun  (in_underrun),
        .out_overflow (out_overflow)
`ifdef CPU_IO_RESPONDER_STATS_EN
        ,
        .words_in     (words_in),
        .words_out    (words_out)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_wr = 1'b0;
        out_rd = 1'b0;
        cpu.IEnable = 1'b0;
        cpu.OEnable = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        in_data = 8'h00;
        cpu.O = 8'h00;
        do_reset();
        checks++;
        if (in_full !== 1'b0 || out_valid !== 1'b0 || in_count !== 5'd0 || out_count !== 5'd0) begin
            errors++;
            $display("FAIL reset_status: in_full=%b out_valid=%b in_count=%0d out_count=%0d want 0 0 0 0",
                     in_full, out_valid, in_count, out_count);
        end
        checks++;
        if (cpu.I !== 8'd0 || in_underrun !== 1'b0 || out_overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_io: I=%0d underrun=%b overflow=%b want 0 0 0",
                     cpu.I, in_underrun, out_overflow);
        end
    endtask

    task automatic test_input_fifo();
        for (int i = 1; i <= 6; i++) begin
            in_wr = 1'b1;
            in_data = 8'(i);
            tick();
        end
        in_wr = 1'b0;
        checks++;
        if (in_count !== 5'd6 || cpu.I !== 8'd1) begin
            errors++;
            $display("FAIL input_fill: in_count=%0d I=%0d want 6 1", in_count, cpu.I);
        end
        for (int k = 0; k < 6; k++) begin
            cpu.IEnable = 1'b1;
            tick();
            cpu.IEnable = 1'b0;
            checks++;
            if (cpu.I !== ((k < 5) ? 8'(k + 2) : 8'd0)) begin
                errors++;
                $display("FAIL input_pop%0d: I=%0d want %0d", k, cpu.I, (k < 5) ? k + 2 : 0);
            end
        end
        checks++;
        if (in_underrun !== 1'b0 || in_count !== 5'd0) begin
            errors++;
            $display("FAIL input_drain: underrun=%b in_count=%0d want 0 0", in_underrun, in_count);
        end
`ifdef CPU_IO_RESPONDER_STATS_EN
        checks++;
        if (words_in !== 16'd6) begin
            errors++;
            $display("FAIL words_in: got %0d want 6", words_in);
        end
`endif
    endtask

    task automatic test_underrun();
        cpu.IEnable = 1'b1;
        tick();
        cpu.IEnable = 1'b0;
        checks++;
        if (cpu.I !== 8'd0 || in_underrun !== 1'b1) begin
            errors++;
            $display("FAIL underrun_set: I=%0d underrun=%b want 0 1", cpu.I, in_underrun);
        end
        // Push and pop together while empty: push lands, pop is an underrun.
        in_wr = 1'b1;
        in_data = 8'h77;
        cpu.IEnable = 1'b1;
        tick();
        idle();
        checks++;
        if (cpu.I !== 8'h77 || in_count !== 5'd1) begin
            errors++;
            $display("FAIL empty_push_pop: I=%h in_count=%0d want 77 1", cpu.I, in_count);
        end
        tick();
        tick();
        checks++;
        if (in_underrun !== 1'b1) begin
            errors++;
            $display("FAIL underrun_sticky: got %b want 1", in_underrun);
        end
    endtask

    task automatic test_output_fifo();
        logic [7:0] exp [3];
        exp[0] = 8'd6;
        exp[1] = 8'd5;
        exp[2] = 8'd4;
        cpu.OEnable = 1'b1;
        cpu.O = 8'd6;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'd6) begin
            errors++;
            $display("FAIL out_latency: out_valid=%b out_data=%0d want 1 6", out_valid, out_data);
        end
        cpu.O = 8'd5;
        tick();
        cpu.O = 8'd4;
        tick();
        cpu.OEnable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (out_data !== exp[k]) begin
                errors++;
                $display("FAIL out_read%0d: got %0d want %0d", k, out_data, exp[k]);
            end
            out_rd = 1'b1;
            tick();
            out_rd = 1'b0;
        end
        checks++;
        if (out_valid !== 1'b0 || out_count !== 5'd0) begin
            errors++;
            $display("FAIL out_drain: out_valid=%b out_count=%0d want 0 0", out_valid, out_count);
        end
        // Pop while empty is harmless.
        out_rd = 1'b1;
        tick();
        out_rd = 1'b0;
        checks++;
        if (out_count !== 5'd0 || out_overflow !== 1'b0) begin
            errors++;
            $display("FAIL out_empty_rd: out_count=%0d overflow=%b want 0 0", out_count, out_overflow);
        end
    endtask

    task automatic fill_output();
        for (int i = 0; i < 16; i++) begin
            cpu.OEnable = 1'b1;
            cpu.O = 8'(8'h10 + i);
            tick();
        end
        cpu.OEnable = 1'b0;
    endtask

    task automatic test_output_overflow();
        fill_output();
        checks++;
        if (out_count !== 5'd16 || out_overflow !== 1'b0) begin
            errors++;
            $display("FAIL out_full: out_count=%0d overflow=%b want 16 0", out_count, out_overflow);
        end
        cpu.OEnable = 1'b1;
        cpu.O = 8'hAA;
        tick();
        cpu.OEnable = 1'b0;
        checks++;
        if (out_overflow !== 1'b1 || out_count !== 5'd16 || out_data !== 8'h10) begin
            errors++;
            $display("FAIL out_overflow: overflow=%b out_count=%0d head=%h want 1 16 10",
                     out_overflow, out_count, out_data);
        end
    endtask

    task automatic test_output_full_rd();
        do_reset();
        fill_output();
        cpu.OEnable = 1'b1;
        cpu.O = 8'hAA;
        out_rd = 1'b1;
        tick();
        idle();
        checks++;
        if (out_overflow !== 1'b0 || out_count !== 5'd16 || out_data !== 8'h11) begin
            errors++;
            $display("FAIL out_full_rd: overflow=%b out_count=%0d head=%h want 0 16 11",
                     out_overflow, out_count, out_data);
        end
        for (int k = 0; k < 15; k++) begin
            out_rd = 1'b1;
            tick();
        end
        out_rd = 1'b0;
        checks++;
        if (out_data !== 8'hAA || out_count !== 5'd1) begin
            errors++;
            $display("FAIL out_tail: head=%h out_count=%0d want aa 1", out_data, out_count);
        end
    endtask

    task automatic test_input_full_push_pop();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            in_wr = 1'b1;
            in_data = 8'(8'h20 + i);
            tick();
        end
        in_wr = 1'b0;
        checks++;
        if (in_full !== 1'b1 || in_count !== 5'd16) begin
            errors++;
            $display("FAIL in_full: in_full=%b in_count=%0d want 1 16", in_full, in_count);
        end
        in_wr = 1'b1;
        in_data = 8'h55;
        cpu.IEnable = 1'b1;
        tick();
        idle();
        checks++;
        if (in_count !== 5'd16 || cpu.I !== 8'h21) begin
            errors++;
            $display("FAIL in_full_push_pop: in_count=%0d I=%h want 16 21", in_count, cpu.I);
        end
        for (int k = 0; k < 15; k++) begin
            cpu.IEnable = 1'b1;
            tick();
        end
        cpu.IEnable = 1'b0;
        checks++;
        if (cpu.I !== 8'h55 || in_count !== 5'd1 || in_underrun !== 1'b0) begin
            errors++;
            $display("FAIL in_wrap: I=%h in_count=%0d underrun=%b want 55 1 0",
                     cpu.I, in_count, in_underrun);
        end
    endtask

    task automatic test_reset_mid_transfer();
        cpu.IEnable = 1'b1;
        tick();
        tick();
        cpu.IEnable = 1'b0;
        in_wr = 1'b1;
        in_data = 8'h33;
        tick();
        tick();
        in_wr = 1'b0;
        fill_output();
        cpu.OEnable = 1'b1;
        tick();
        checks++;
        if (in_underrun !== 1'b1 || out_overflow !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_flags: underrun=%b overflow=%b want 1 1", in_underrun, out_overflow);
        end
        rst = 1'b1;
        in_wr = 1'b1;
        cpu.OEnable = 1'b1;
        cpu.IEnable = 1'b1;
        out_rd = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        checks++;
        if (in_count !== 5'd0 || out_count !== 5'd0 || out_valid !== 1'b0 || cpu.I !== 8'd0) begin
            errors++;
            $display("FAIL mid_reset_counts: in_count=%0d out_count=%0d out_valid=%b I=%0d want 0 0 0 0",
                     in_count, out_count, out_valid, cpu.I);
        end
        checks++;
        if (in_underrun !== 1'b0 || out_overflow !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_flags: underrun=%b overflow=%b want 0 0", in_underrun, out_overflow);
        end
`ifdef CPU_IO_RESPONDER_STATS_EN
        checks++;
        if (words_in !== 16'd0 || words_out !== 16'd0) begin
            errors++;
            $display("FAIL mid_reset_stats: words_in=%0d words_out=%0d want 0 0", words_in, words_out);
        end
`endif
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_input_fifo();
        test_underrun();
        test_output_fifo();
        test_output_overflow();
        test_output_full_rd();
        test_input_full_push_pop();
        test_reset_mid_transfer();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
